// File: rtl/uart_tx_pkg.sv
// Shared UART constants and sizing helpers for the debug-unit serial path.
// Defaults: 8 data bits, one 16-tick stop bit, 16x oversampling.
package uart_tx_pkg;

    localparam int UART_BITS       = 8;
    localparam int UART_SB_TICK    = 16;
    localparam int UART_OVERSAMPLE = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width that can hold n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte one cycle after the start strobe and holds o_tx_done low for
// (1+DATA_BITS)*OVERSAMPLE+SB_TICK ticks. There is no queue: starts are ignored while busy.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_BITS  = UART_BITS,
    parameter int SB_TICK    = UART_SB_TICK,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_tick,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_tx,
    output logic                 o_tx_done
);

    localparam int TICK_W = cnt_width(max_int(OVERSAMPLE, SB_TICK));
    localparam int BIT_W  = cnt_width(DATA_BITS);

    localparam logic [TICK_W-1:0] OS_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e                 state_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [TICK_W-1:0]      tick_q;
    logic [BIT_W-1:0]       bit_q;
    logic                   tx_q;
    logic                   done_q;

    // The line register is loaded with the level of the state being entered,
    // so o_tx moves on the same edge as state_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    done_q <= 1'b1;
                    if (i_tx_start) begin
                        shift_q <= i_data;
                        tick_q  <= '0;
                        tx_q    <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= START;
                    end
                end

                START: begin
                    if (i_tick) begin
                        if (tick_q == OS_LAST) begin
                            tick_q  <= '0;
                            bit_q   <= '0;
                            tx_q    <= shift_q[0];
                            state_q <= DATA;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (i_tick) begin
                        if (tick_q == OS_LAST) begin
                            tick_q  <= '0;
                            shift_q <= shift_q >> 1;
                            if (bit_q == BIT_LAST) begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                                tx_q  <= shift_q[1];
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (i_tick) begin
                        if (tick_q == SB_LAST) begin
                            tick_q  <= '0;
                            tx_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end

                default: begin
                    tick_q  <= '0;
                    tx_q    <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_tx      = tx_q;
    assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames checked against a cycle-exact line model,
// plus hand sequences for reset, idle stability, busy-start rejection and mid-frame reset.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       i_tick;
    logic       i_tx_start;
    logic [7:0] i_data;
    logic       o_tx;
    logic       o_tx_done;

    int tests = 0;
    int fails = 0;

    uart_tx dut (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (i_tick),
        .i_tx_start (i_tx_start),
        .i_data     (i_data),
        .o_tx       (o_tx),
        .o_tx_done  (o_tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         div;
        logic [7:0] exp_byte;
        int         exp_len;
        bit         disturb;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller must be sampling right after an edge with o_tx_done high.
    // The strobe edge also carries a tick, which must not be counted.
    task automatic run_frame(input vec_t v);
        int         tx_bad;
        int         done_bad;
        int         bitlen;
        int         idx;
        logic       exp_tx;
        logic       exp_done;
        logic [7:0] dec;
        bitlen   = 16 * v.div;
        tx_bad   = 0;
        done_bad = 0;
        dec      = 8'h00;
        i_data     = v.data;
        i_tx_start = 1'b1;
        i_tick     = 1'b1;
        for (int j = 0; j <= v.exp_len; j++) begin
            @(posedge clk); #1;
            idx = j / bitlen;
            if (j == v.exp_len)  exp_tx = 1'b1;
            else if (idx == 0)   exp_tx = 1'b0;
            else if (idx <= 8)   exp_tx = v.exp_byte[idx-1];
            else                 exp_tx = 1'b1;
            exp_done = (j == v.exp_len);
            if (o_tx !== exp_tx)      tx_bad++;
            if (o_tx_done !== exp_done) done_bad++;
            if (idx >= 1 && idx <= 8 && (j % bitlen) == bitlen / 2)
                dec[idx-1] = o_tx;
            i_tx_start = v.disturb && (j == 40);
            if (v.disturb && j == 40) i_data = 8'hFF;
            if (v.disturb && j == 70) i_data = 8'h0F;
            i_tick = (((j + 1) % v.div) == 0);
        end
        check($sformatf("frame_%02h_div%0d_line_errs", v.data, v.div), tx_bad, 0);
        check($sformatf("frame_%02h_div%0d_done_errs", v.data, v.div), done_bad, 0);
        check($sformatf("frame_%02h_div%0d_decoded", v.data, v.div), {24'h0, dec}, {24'h0, v.exp_byte});
    endtask

    vec_t vecs[6];

    initial begin
        int bad_tx;
        int bad_done;

        vecs[0] = '{data: 8'hA5, div: 1, exp_byte: 8'hA5, exp_len: 160, disturb: 1'b0};
        vecs[1] = '{data: 8'hA5, div: 1, exp_byte: 8'hA5, exp_len: 160, disturb: 1'b1};
        vecs[2] = '{data: 8'h3C, div: 4, exp_byte: 8'h3C, exp_len: 640, disturb: 1'b0};
        vecs[3] = '{data: 8'h00, div: 1, exp_byte: 8'h00, exp_len: 160, disturb: 1'b0};
        vecs[4] = '{data: 8'hFF, div: 1, exp_byte: 8'hFF, exp_len: 160, disturb: 1'b0};
        vecs[5] = '{data: 8'hC3, div: 2, exp_byte: 8'hC3, exp_len: 320, disturb: 1'b1};

        rst        = 1'b0;
        i_tick     = 1'b1;
        i_tx_start = 1'b0;
        i_data     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", o_tx, 1'b1);
        check("reset_done", o_tx_done, 1'b1);

        // Idle with free-running ticks and no start must not move the line.
        rst    = 1'b1;
        bad_tx = 0;
        bad_done = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (o_tx !== 1'b1)      bad_tx++;
            if (o_tx_done !== 1'b1) bad_done++;
        end
        check("idle_tx_errs", bad_tx, 0);
        check("idle_done_errs", bad_done, 0);

        // Consecutive entries also exercise back-to-back starts on the first done cycle.
        foreach (vecs[k]) run_frame(vecs[k]);

        // Mid-frame reset during data bit 3 of 0x55 (bit value 0).
        i_data     = 8'h55;
        i_tx_start = 1'b1;
        i_tick     = 1'b1;
        for (int j = 0; j <= 72; j++) begin
            @(posedge clk); #1;
            i_tx_start = 1'b0;
            i_data     = 8'h00;
            i_tick     = 1'b1;
        end
        check("pre_reset_bit3_tx", o_tx, 1'b0);
        check("pre_reset_done", o_tx_done, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midreset_tx", o_tx, 1'b1);
        check("midreset_done", o_tx_done, 1'b1);
        rst    = 1'b1;
        bad_tx = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (o_tx !== 1'b1 || o_tx_done !== 1'b1) bad_tx++;
        end
        check("post_reset_idle_errs", bad_tx, 0);
        run_frame('{data: 8'h81, div: 1, exp_byte: 8'h81, exp_len: 160, disturb: 1'b0});

        // With no ticks the FSM must hold START indefinitely.
        i_data     = 8'h5A;
        i_tx_start = 1'b1;
        i_tick     = 1'b0;
        @(posedge clk); #1;
        i_tx_start = 1'b0;
        bad_tx = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (o_tx !== 1'b0 || o_tx_done !== 1'b0) bad_tx++;
        end
        check("no_tick_hold_errs", bad_tx, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter for the debug unit, directly downstream of the debug send FSM.
- Takes a one-cycle start strobe plus a byte and serialises it as an 8N1 frame on the TX line.
- Frame order: start bit, data LSB first, stop bit(s), timed by an external 16x oversampling tick.
- Reports readiness through a level done flag that the send FSM polls before every byte.

Parameters:
- DATA_BITS, `UART_BITS (8): data bits per frame.
- SB_TICK, `UART_SB_TICK (16): ticks spent in the stop state; 16 means 1 stop bit.
- OVERSAMPLE, `UART_OVERSAMPLE (16): ticks per start/data bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- i_tick  in  1  one-cycle pulse at baud*OVERSAMPLE rate, from the shared baud generator.
- i_tx_start  in  1  request to send i_data; sampled only when idle.
- i_data  in  DATA_BITS  byte to send; latched on acceptance.
- o_tx  out  1  serial line, registered, idle high.
- o_tx_done  out  1  level: high = idle and able to accept a byte.

Behaviour:
- One clock; reset is synchronous and active-low. At reset: state IDLE, o_tx=1, o_tx_done=1, tick and bit counters 0.
- States: IDLE, START, DATA, STOP. Registers: shift register (DATA_BITS wide), tick counter (log2 OVERSAMPLE/SB_TICK), bit counter (log2 DATA_BITS).
- IDLE:
  - o_tx=1, o_tx_done=1.
  - When i_tx_start=1: latch i_data into the shift register, clear the tick counter, go to START, drive o_tx_done<=0.
  - Acceptance is independent of i_tick.
  - o_tx_done is low on the cycle after the strobe, so a poll two cycles after the strobe sees busy.
- START:
  - o_tx=0.
  - Each i_tick increments the tick counter.
  - On a tick with counter == OVERSAMPLE-1: clear tick counter and bit counter, go to DATA.
- DATA:
  - o_tx = shift[0].
  - On a tick with counter == OVERSAMPLE-1: shift right by 1 and increment the bit counter.
  - After bit DATA_BITS-1 completes, go to STOP.
- STOP:
  - o_tx=1.
  - On a tick with counter == SB_TICK-1: go to IDLE and drive o_tx_done<=1.
- o_tx is a register updated from next-state logic, so the line changes on the same edge as the state change and never glitches.
- Frame duration: (1+DATA_BITS)*OVERSAMPLE + SB_TICK ticks after acceptance, which is 160 ticks for defaults.
- Boundary conditions:
  - i_tx_start while busy is ignored, with no queueing.
  - i_data changes after acceptance have no effect.
  - i_tick coinciding with an accepted start is not counted; counting begins with the next tick.
  - i_tick absent: the FSM holds its state indefinitely.
  - Back-to-back: a start asserted on the first cycle o_tx_done is high is accepted, with no extra idle time beyond the stop bit.
  - Reset mid-frame: next edge gives o_tx=1, o_tx_done=1, IDLE, and the partial frame is abandoned.
  - Counters never wrap in normal operation; each state clears its tick counter on exit.

Decomposition:
- Add `UART_SB_TICK and `UART_OVERSAMPLE to constants.vh, next to `UART_BITS.
- State encodings are local to the module.
- No sub-module. The tick comes from the existing shared baud-rate generator, which is instanced once and fans out to uart_tx and the receiver.

Test Plan:
1. Reset with i_tick=1 every cycle -> o_tx=1, o_tx_done=1; no change for 50 cycles without a start.
2. Start with 0xA5, tick every cycle -> o_tx: 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then 1 for 16 cycles. o_tx_done low from the cycle after the strobe; high again 160 cycles after acceptance.
3. During the 0xA5 frame, assert i_tx_start with i_data=0xFF and also change i_data mid-frame -> captured frame is still exactly 0xA5; o_tx_done unaffected.
4. Tick every 4th cycle, send 0x3C -> frame lasts 640 cycles; decoded byte is 0x3C.
5. Bench model of the send FSM (1-cycle start whenever o_tx_done=1, data 0x00 then 0xFF) -> two contiguous frames with no idle gap; o_tx_done low within 1 cycle of each strobe; bench decodes 0x00, 0xFF.
6. Reset asserted at DATA bit 3 of 0x55 -> next cycle o_tx=1, o_tx_done=1. After release, send 0x81 -> correct frame decoded.
